or_unit_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one ready/enable two-operand OR unit between NUM_REQ clients.

---
 rtl/or_unit_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/or_unit_arbiter.sv
`timescale 1ns/1ps
// or_unit_arbiter
// Shares one ready/enable two-operand OR unit between NUM_REQ clients.
// Clients are picked round-robin. One transaction is in flight at a time.
// The response carries the result and the id of the client that was served.
// A watchdog covers the ISSUE and WAIT states. If the unit stalls, it
// returns an error response with zero data and does not drain the unit.
module or_unit_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int W        = 1,
    parameter int TIMEOUT  = 64,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req_en,
    output logic [NUM_REQ-1:0]   req_rdy,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic                 rsp_en,
    input  logic                 rsp_rdy,
    output logic [W-1:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err,
    output logic [W-1:0]         u_a_data,
    output logic                 u_a_en,
    input  logic                 u_a_rdy,
    output logic [W-1:0]         u_b_data,
    output logic                 u_b_en,
    input  logic                 u_b_rdy,
    input  logic [W-1:0]         u_y_data,
    input  logic                 u_y_ready,
    output logic                 u_y_en
);

    localparam int IDW1 = IDW + 1;
    localparam int WDW  = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       r_id;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic                 r_a_done;
    logic                 r_b_done;
    logic [WDW-1:0]       r_wd_cnt;
    logic [W-1:0]         r_rsp_data;
    logic                 r_rsp_err;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDW-1:0]       w_gnt_id;
    logic                 w_found;
    logic [IDW1-1:0]      w_sum;
    logic [IDW-1:0]       w_idx;
    logic [NUM_REQ-1:0]   w_req_rdy;
    logic                 w_u_a_en;
    logic                 w_u_b_en;
    logic                 w_u_y_en;
    logic                 w_timeout;
    logic                 w_rsp_fire;
    logic                 w_a_fire;
    logic                 w_b_fire;
    logic                 w_y_fire;
    logic [W-1:0]         w_sel_a;
    logic [W-1:0]         w_sel_b;

    assign w_a_fire = w_u_a_en && u_a_rdy;
    assign w_b_fire = w_u_b_en && u_b_rdy;
    assign w_y_fire = w_u_y_en && u_y_ready;
    assign w_sel_a  = req_a[w_gnt_id*W +: W];
    assign w_sel_b  = req_b[w_gnt_id*W +: W];

    // Round-robin search: first requesting client at or above rr_ptr, with wrap.
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + IDW1'(k);
            if (w_sum >= IDW1'(NUM_REQ)) begin
                w_sum = w_sum - IDW1'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && req_en[w_idx]) begin
                w_found         = 1'b1;
                w_grant[w_idx]  = 1'b1;
                w_gnt_id        = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and handshake decode for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_req_rdy   = '0;
        w_u_a_en    = 1'b0;
        w_u_b_en    = 1'b0;
        w_u_y_en    = 1'b0;
        w_timeout   = 1'b0;
        w_rsp_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // No grant while reset is held, so nothing is granted during the reset cycle.
                w_req_rdy   = RST ? '0 : w_grant;
                w_state_nxt = (|w_grant) ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                w_timeout = (r_wd_cnt == WD_LAST);
                if (w_timeout) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_u_a_en = !r_a_done;
                    w_u_b_en = !r_b_done;
                    if ((r_a_done || (w_u_a_en && u_a_rdy)) &&
                        (r_b_done || (w_u_b_en && u_b_rdy))) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_WAIT: begin
                w_timeout = (r_wd_cnt == WD_LAST);
                if (w_timeout) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_u_y_en    = u_y_ready;
                    w_state_nxt = u_y_ready ? S_RESP : S_WAIT;
                end
            end
            S_RESP: begin
                w_rsp_fire  = rsp_rdy;
                w_state_nxt = rsp_rdy ? S_IDLE : S_RESP;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transaction datapath: operand latch, done flags, watchdog, response and rr pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_a_done   <= 1'b0;
            r_b_done   <= 1'b0;
            r_wd_cnt   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req_rdy) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_id     <= w_gnt_id;
                        r_a_done <= 1'b0;
                        r_b_done <= 1'b0;
                        r_wd_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    r_wd_cnt <= r_wd_cnt + WDW'(1);
                    if (w_a_fire) begin
                        r_a_done <= 1'b1;
                    end
                    if (w_b_fire) begin
                        r_b_done <= 1'b1;
                    end
                    if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_wd_cnt <= r_wd_cnt + WDW'(1);
                    if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end else if (w_y_fire) begin
                        r_rsp_data <= u_y_data;
                        r_rsp_err  <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (w_rsp_fire) begin
                        r_rr_ptr <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : (r_id + IDW'(1));
                    end
                end
                default: begin
                    r_wd_cnt <= '0;
                end
            endcase
        end
    end

    assign req_rdy  = w_req_rdy;
    assign rsp_en   = (r_state == S_RESP);
    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_id;
    assign rsp_err  = r_rsp_err;
    assign u_a_data = r_a;
    assign u_b_data = r_b;
    assign u_a_en   = w_u_a_en;
    assign u_b_en   = w_u_b_en;
    assign u_y_en   = w_u_y_en;

endmodule
